// File: rtl/ext_pkg.sv
// Shared definitions for the pipelined immediate/load-data extender.
// Mode encodings are the 4-bit in_mode values; codes 8-15 are unused.
package ext_pkg;

   localparam int EXT_MODE_W = 4;

   typedef enum logic [EXT_MODE_W-1:0] {
      EXT_SIG   = 4'd0,
      EXT_UNSIG = 4'd1,
      EXT_LUI   = 4'd2,
      EXT_LB    = 4'd3,
      EXT_LBU   = 4'd4,
      EXT_LH    = 4'd5,
      EXT_LHU   = 4'd6,
      EXT_LW    = 4'd7
   } ext_mode_e;

endpackage

// File: rtl/ext_core.sv
// Combinational mode/offset decode: immediate extension, load-data lane
// selection and extension, and misalignment detection.
module ext_core
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int OFS_W  = $clog2(DATA_W/8)
) (
   input  logic [EXT_MODE_W-1:0] mode,
   input  logic [IMM_W-1:0]      imm,
   input  logic [DATA_W-1:0]     word,
   input  logic [OFS_W-1:0]      offset,
   output logic [DATA_W-1:0]     data,
   output logic                  misalign
);

   logic signed [IMM_W-1:0] imm_s;
   logic signed [7:0]       byte_s;
   logic signed [15:0]      half_s;
   logic signed [31:0]      word_s;

   always_comb begin
      imm_s    = imm;
      byte_s   = word[{offset, 3'b000} +: 8];
      half_s   = word[{offset[OFS_W-1:1], 4'b0000} +: 16];
      word_s   = word[31:0];
      data     = '0;
      misalign = 1'b0;
      // Sized casts of signed operands sign-extend; unsigned ones zero-extend.
      case (mode)
         EXT_SIG:   data = DATA_W'(imm_s);
         EXT_UNSIG: data = DATA_W'(imm);
         EXT_LUI:   data = DATA_W'(imm) << (DATA_W - IMM_W);
         EXT_LB:    data = DATA_W'(byte_s);
         EXT_LBU:   data = DATA_W'(byte_s[7:0]);
         EXT_LH: begin
            if (offset[0]) misalign = 1'b1;
            else           data     = DATA_W'(half_s);
         end
         EXT_LHU: begin
            if (offset[0]) misalign = 1'b1;
            else           data     = DATA_W'(half_s[15:0]);
         end
         EXT_LW: begin
            if (offset[1:0] != 2'b00) misalign = 1'b1;
            else                      data     = DATA_W'(word_s);
         end
         default: begin
            data     = '0;
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extender: ext_core result registered into a main output stage
// backed by a one-entry skid register, with valid/ready on both sides.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int OFS_W  = $clog2(DATA_W/8)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXT_MODE_W-1:0] in_mode,
   input  logic [IMM_W-1:0]      in_imm,
   input  logic [DATA_W-1:0]     in_word,
   input  logic [OFS_W-1:0]      in_offset,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_misalign
);

   logic [DATA_W-1:0] core_data;
   logic              core_misalign;

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              main_mis_q,   main_mis_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              skid_mis_q,   skid_mis_d;

   logic accept;
   logic drain;

   ext_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .OFS_W  (OFS_W)
   ) u_core (
      .mode     (in_mode),
      .imm      (in_imm),
      .word     (in_word),
      .offset   (in_offset),
      .data     (core_data),
      .misalign (core_misalign)
   );

   assign in_ready     = ~skid_valid_q & ~reset;
   assign out_valid    = main_valid_q;
   assign out_data     = main_data_q;
   assign out_misalign = main_mis_q;

   always_comb begin
      accept       = in_valid & in_ready;
      drain        = main_valid_q & out_ready;
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_mis_d   = main_mis_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_mis_d   = skid_mis_q;
      // A full skid blocks accept, so refilling main from skid never races a new beat.
      if (drain && skid_valid_q) begin
         main_data_d  = skid_data_q;
         main_mis_d   = skid_mis_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!main_valid_q || drain)) begin
         main_valid_d = 1'b1;
         main_data_d  = core_data;
         main_mis_d   = core_misalign;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = core_data;
         skid_mis_d   = core_misalign;
      end else if (drain) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_mis_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_mis_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_mis_q   <= main_mis_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_mis_q   <= skid_mis_d;
      end
   end

endmodule
